// File: rtl/serial_tx_sequencer.sv
// serial_tx_sequencer: drives load/shift enables for an external LSB-first shift register,
// framing each DATA_SIZE-bit frame and inserting GAP_CYCLES idle cycles between frames.
module serial_tx_sequencer #(
    parameter int DATA_SIZE  = 64,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 sink_ready,
    input  logic                 abort,
    output logic [DATA_SIZE-1:0] sr_data,
    output logic                 sr_load_en,
    output logic                 sr_shift_en,
    output logic                 bit_valid,
    output logic                 frame_first,
    output logic                 frame_last,
    output logic                 busy
);
    localparam int CW = $clog2(DATA_SIZE);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_SIZE - 1);
    localparam logic [7:0] GAP_INIT = 8'(GAP_CYCLES);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]    r_gap_cnt, w_gap_cnt_nxt;
    logic          w_at_last;

    assign sr_data     = data_in;
    assign busy        = r_state != IDLE;
    assign in_ready    = rst_n && r_state == IDLE && !abort;
    assign sr_load_en  = in_valid && in_ready;
    assign sr_shift_en = rst_n && r_state == SHIFT && sink_ready && !abort;
    assign w_at_last   = r_bit_cnt == LAST_BIT;

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        if (sr_load_en) begin
            w_state_nxt   = SHIFT;
            w_bit_cnt_nxt = '0;
        end else if (busy && abort) begin
            w_state_nxt   = IDLE;
            w_gap_cnt_nxt = '0;
        end else if (sr_shift_en) begin
            // the counter parks on the last bit instead of wrapping; the next load clears it
            w_bit_cnt_nxt = w_at_last ? r_bit_cnt : r_bit_cnt + CW'(1);
            if (w_at_last) begin
                w_gap_cnt_nxt = GAP_INIT;
                if (GAP_CYCLES == 0) w_state_nxt = IDLE;
                else w_state_nxt = GAP;
            end
        end else if (r_state == GAP) begin
            w_gap_cnt_nxt = r_gap_cnt - 8'd1;
            if (r_gap_cnt == 8'd1) w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            bit_valid   <= 1'b0;
            frame_first <= 1'b0;
            frame_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            bit_valid   <= sr_shift_en;
            frame_first <= sr_shift_en && r_bit_cnt == '0;
            frame_last  <= sr_shift_en && w_at_last;
        end
    end
endmodule

// File: tb/tb_serial_tx_sequencer.sv
// tb_serial_tx_sequencer: scoreboard bench with behavioural shift registers behind two sequencers (gap 2 and gap 0).
module tb_serial_tx_sequencer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [W-1:0] data_a, srd_a, data_b, srd_b;
    logic iv_a, ir_a, sk_a, ab_a, ld_a, sh_a, bv_a, ff_a, fl_a, bz_a;
    logic iv_b, ir_b, sk_b, ab_b, ld_b, sh_b, bv_b, ff_b, fl_b, bz_b;

    serial_tx_sequencer #(.DATA_SIZE(W), .GAP_CYCLES(2)) u_a (
        .clk(clk), .rst_n(rst_n), .data_in(data_a), .in_valid(iv_a), .in_ready(ir_a),
        .sink_ready(sk_a), .abort(ab_a), .sr_data(srd_a), .sr_load_en(ld_a), .sr_shift_en(sh_a),
        .bit_valid(bv_a), .frame_first(ff_a), .frame_last(fl_a), .busy(bz_a)
    );

    serial_tx_sequencer #(.DATA_SIZE(W), .GAP_CYCLES(0)) u_b (
        .clk(clk), .rst_n(rst_n), .data_in(data_b), .in_valid(iv_b), .in_ready(ir_b),
        .sink_ready(sk_b), .abort(ab_b), .sr_data(srd_b), .sr_load_en(ld_b), .sr_shift_en(sh_b),
        .bit_valid(bv_b), .frame_first(ff_b), .frame_last(fl_b), .busy(bz_b)
    );

    typedef struct packed {logic b; logic f; logic l;} exp_t;
    exp_t qa[$];
    exp_t qb[$];
    int total = 0;
    int bad = 0;
    logic [W-1:0] sr_a, sr_b;
    logic so_a, so_b;
    int ns_a = 0;
    int nv_a = 0;
    int nv_b = 0;
    int idle_b = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // external shift registers: one-cycle latency from shift enable to serial output
    always @(posedge clk) begin
        if (ld_a) sr_a <= srd_a;
        else if (sh_a) begin
            sr_a <= sr_a >> 1;
            so_a <= sr_a[0];
            ns_a <= ns_a + 1;
        end
        if (ld_b) sr_b <= srd_b;
        else if (sh_b) begin
            sr_b <= sr_b >> 1;
            so_b <= sr_b[0];
        end
    end

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (bv_a) begin
            nv_a <= nv_a + 1;
            chk("a_q_nonempty", qa.size() != 0, 1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("a_bit", so_a, e.b);
                chk("a_first", ff_a, e.f);
                chk("a_last", fl_a, e.l);
            end
        end else chk("a_flags_idle", {ff_a, fl_a}, 0);
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (bv_b) begin
            if (nv_b == 8) chk("b_gap_one", idle_b, 1);
            nv_b <= nv_b + 1;
            idle_b <= 0;
            chk("b_q_nonempty", qb.size() != 0, 1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("b_bit", so_b, e.b);
                chk("b_first", ff_b, e.f);
                chk("b_last", fl_b, e.l);
            end
        end else begin
            if (nv_b > 0) idle_b <= idle_b + 1;
            chk("b_flags_idle", {ff_b, fl_b}, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit which, input logic [W-1:0] d);
        exp_t e;
        for (int k = 0; k < W; k++) begin
            e.b = d[k];
            e.f = (k == 0);
            e.l = (k == W - 1);
            if (which) qb.push_back(e);
            else qa.push_back(e);
        end
    endtask

    task automatic send_a(input logic [W-1:0] d);
        push(1'b0, d);
        data_a = d;
        iv_a = 1'b1;
        #0;
        for (int i = 0; i < 50 && !ld_a; i++) tick();
        chk("a_load_seen", ld_a, 1);
        tick();
        iv_a = 1'b0;
    endtask

    task automatic wait_shift_a(input int t);
        for (int i = 0; i < 100 && ns_a < t; i++) tick();
        chk("a_shift_timeout", ns_a == t, 1);
    endtask

    task automatic wait_idle_a();
        for (int i = 0; i < 100 && bz_a; i++) tick();
        chk("a_idle_timeout", bz_a, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, v0;
        iv_a = 0; data_a = '0; sk_a = 1; ab_a = 0;
        iv_b = 0; data_b = '0; sk_b = 1; ab_b = 0;
        #2 rst_n = 1'b0;
        iv_a = 1'b1;
        #1;
        chk("rst_in_ready", ir_a, 0);
        chk("rst_load", ld_a, 0);
        chk("rst_shift", sh_a, 0);
        chk("rst_busy", bz_a, 0);
        chk("rst_bit_valid", bv_a, 0);
        chk("rst_flags", {ff_a, fl_a}, 0);
        repeat (3) tick();
        chk("rst_in_ready_hold", ir_a, 0);
        iv_a = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        #1 chk("post_rst_ready", ir_a, 1);

        // A5 with gap 2: in_ready returns three cycles after the last shift
        v0 = nv_a;
        send_a(8'hA5);
        s0 = ns_a;
        wait_shift_a(s0 + 8);
        chk("gap_ready1", ir_a, 0);
        tick();
        chk("gap_ready2", ir_a, 0);
        chk("gap_busy", bz_a, 1);
        tick();
        chk("gap_ready3", ir_a, 1);
        chk("gap_idle", bz_a, 0);
        chk("a5_count", nv_a - v0, 8);
        chk("a5_q_empty", qa.size(), 0);

        // five-cycle stall after the third shift
        v0 = nv_a;
        send_a(8'hC6);
        s0 = ns_a;
        wait_shift_a(s0 + 3);
        sk_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #0 chk("stall_no_shift", sh_a, 0);
            tick();
        end
        chk("stall_held", ns_a - s0, 3);
        chk("stall_bv", nv_a - v0, 3);
        sk_a = 1'b1;
        wait_idle_a();
        tick();
        chk("stall_count", nv_a - v0, 8);
        chk("stall_q_empty", qa.size(), 0);

        // abort after the fourth shift
        v0 = nv_a;
        send_a(8'h96);
        s0 = ns_a;
        wait_shift_a(s0 + 4);
        ab_a = 1'b1;
        #1;
        chk("abort_no_shift", sh_a, 0);
        chk("abort_no_ready", ir_a, 0);
        tick();
        ab_a = 1'b0;
        chk("abort_idle", bz_a, 0);
        chk("abort_bv_count", nv_a - v0, 4);
        qa.delete();
        repeat (3) tick();
        chk("abort_no_more", ns_a - s0, 4);
        v0 = nv_a;
        send_a(8'h3C);
        wait_idle_a();
        tick();
        chk("3c_count", nv_a - v0, 8);
        chk("3c_q_empty", qa.size(), 0);

        // in_valid pulsed mid-frame must be ignored
        v0 = nv_a;
        send_a(8'h5A);
        s0 = ns_a;
        wait_shift_a(s0 + 2);
        iv_a = 1'b1;
        data_a = 8'h00;
        #1;
        chk("busy_no_ready", ir_a, 0);
        chk("busy_no_load", ld_a, 0);
        tick();
        iv_a = 1'b0;
        wait_idle_a();
        tick();
        chk("5a_count", nv_a - v0, 8);
        chk("5a_q_empty", qa.size(), 0);

        // asynchronous reset between edges mid-frame
        send_a(8'hE7);
        s0 = ns_a;
        wait_shift_a(s0 + 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", bz_a, 0);
        chk("arst_bv", bv_a, 0);
        qa.delete();
        repeat (2) tick();
        @(negedge clk) rst_n = 1'b1;
        v0 = nv_a;
        send_a(8'hFF);
        wait_idle_a();
        tick();
        chk("ff_count", nv_a - v0, 8);
        chk("ff_q_empty", qa.size(), 0);

        // gap 0, in_valid held across two frames
        push(1'b1, 8'h01);
        push(1'b1, 8'h80);
        data_b = 8'h01;
        iv_b = 1'b1;
        #0;
        for (int i = 0; i < 50 && !ld_b; i++) tick();
        chk("b_load1", ld_b, 1);
        tick();
        data_b = 8'h80;
        #0;
        for (int i = 0; i < 50 && !ld_b; i++) tick();
        chk("b_load2", ld_b, 1);
        tick();
        iv_b = 1'b0;
        for (int i = 0; i < 100 && bz_b; i++) tick();
        chk("b_idle_timeout", bz_b, 0);
        tick();
        chk("b_count", nv_b, 16);
        chk("b_q_empty", qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
